matvec_engine: RTL and testbench

Signed matrix-vector multiply engine that produces the `matrix_result`/`matrix_valid` stream consumed by the neural layer stage. It holds an M×N weight matrix and an N-entry input vector in local register memories. On `start` it computes the M row dot products sequentially, one MAC per cycle. Each saturated 2*DATA_WIDTH result is handed downstream through a valid/ready handshake, followed by a one-cycle `done` pulse.

---
 rtl/matvec_engine.sv | 145 ++++++++++++++
 tb/tb_matvec_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// Signed M x N matrix-vector engine: one MAC per cycle, saturated row results
// streamed out over a valid/ready handshake, then a one-cycle done pulse.
module matvec_engine #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    localparam int WAW = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int CW  = (N > 1) ? $clog2(N) : 1,
    localparam int RAW = (M > 1) ? $clog2(M) : 1,
    localparam int RW  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_wen,
    input  logic [WAW-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_wen,
    input  logic [CW-1:0]         x_addr,
    input  logic                  matrix_ready,
    output logic [RW-1:0]         matrix_result,
    output logic                  matrix_valid,
    output logic [RAW-1:0]        row_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = RW + $clog2(N) + 1;

    localparam logic signed [AW-1:0] SMAX =
        AW'({1'b0, {(RW-1){1'b1}}});
    localparam logic signed [AW-1:0] SMIN =
        {{(AW-RW+1){1'b1}}, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic [CW-1:0]          col_q;
    logic [RAW-1:0]         row_q;
    logic [RW-1:0]          res_q;
    logic [RW-1:0]          res_d;
    logic                   valid_q;
    logic                   done_q;

    // Weight/vector storage is deliberately left out of reset.
    logic signed [DATA_WIDTH-1:0] w_mem [M*N];
    logic signed [DATA_WIDTH-1:0] x_mem [N];

    logic [WAW-1:0]         w_idx;
    logic signed [RW-1:0]   prod;

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            if (w_wen && int'(w_addr) < M * N) begin
                w_mem[w_addr] <= w_in;
            end
            if (x_wen && int'(x_addr) < N) begin
                x_mem[x_addr] <= x_in;
            end
        end
    end

    always_comb begin
        w_idx = WAW'(int'(row_q) * N + int'(col_q));
        prod  = RW'(w_mem[w_idx]) * RW'(x_mem[col_q]);
        acc_d = acc_q + AW'(prod);
        res_d = acc_d[RW-1:0];
        if (acc_d > SMAX) begin
            res_d = SMAX[RW-1:0];
        end else if (acc_d < SMIN) begin
            res_d = SMIN[RW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_MAC;
                        acc_q   <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (col_q == CW'(N - 1)) begin
                        res_q   <= res_d;
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_OUT: begin
                    if (valid_q && matrix_ready) begin
                        valid_q <= 1'b0;
                        if (row_q == RAW'(M - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            row_q   <= row_q + RAW'(1);
                            acc_q   <= '0;
                            col_q   <= '0;
                            state_q <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    // Two cycles here: one to raise done, one to drop it.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign matrix_result = res_q;
    assign matrix_valid  = valid_q;
    assign row_idx       = row_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Randomized self-checking bench for matvec_engine against an
// arithmetic reference model of the row dot products.
module tb_matvec_engine;

    localparam int M  = 3;
    localparam int N  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_wen = 1'b0;
    logic [3:0]    w_addr = '0;
    logic [DW-1:0] x_in = '0;
    logic          x_wen = 1'b0;
    logic [1:0]    x_addr = '0;
    logic          matrix_ready = 1'b1;
    logic [15:0]   matrix_result;
    logic          matrix_valid;
    logic [1:0]    row_idx;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int W[M*N];
    int X[N];

    matvec_engine #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .w_in         (w_in),
        .w_wen        (w_wen),
        .w_addr       (w_addr),
        .x_in         (x_in),
        .x_wen        (x_wen),
        .x_addr       (x_addr),
        .matrix_ready (matrix_ready),
        .matrix_result(matrix_result),
        .matrix_valid (matrix_valid),
        .row_idx      (row_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_row(input int r);
        int s = 0;
        for (int c = 0; c < N; c++) s += W[r*N+c] * X[c];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s & 32'hFFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_all();
        for (int i = 0; i < M * N; i++) begin
            w_wen = 1'b1; w_addr = 4'(i); w_in = 8'(W[i]);
            step();
        end
        w_wen = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_wen = 1'b1; x_addr = 2'(i); x_in = 8'(X[i]);
            step();
        end
        x_wen = 1'b0;
    endtask

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < M * N; i++) W[i] = wv;
        for (int i = 0; i < N; i++) X[i] = xv;
    endtask

    function automatic int rnd8();
        int v;
        v = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) != 0) ? 127 : -128;
        return v;
    endfunction

    task automatic run(input string nm, input int srow, input int slen,
                       input bit junk);
        int cyc = 0;
        int seen = 0;
        int stalled = 0;
        int vcyc = 0;
        int done_cyc = -1;
        bit fresh = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, ":busy"}, 32'(busy), 1);
        while (cyc < 200 && done_cyc < 0) begin
            start = 1'b0; w_wen = 1'b0; x_wen = 1'b0;
            matrix_ready = 1'b1;
            if (done) begin
                done_cyc = cyc;
                chk({nm, ":valid_at_done"}, 32'(matrix_valid), 0);
            end else if (matrix_valid) begin
                vcyc++;
                chk({nm, ":row"}, 32'(row_idx), 32'(seen));
                chk({nm, ":res"}, 32'(matrix_result), 32'(exp_row(seen)));
                if (fresh) begin
                    chk({nm, ":vcyc"}, 32'(cyc),
                        32'(N + seen*(N+1) + ((seen > srow) ? slen : 0)));
                    fresh = 1'b0;
                end
                if (seen == srow && stalled < slen) begin
                    matrix_ready = 1'b0;
                    stalled++;
                end else begin
                    seen++;
                    fresh = 1'b1;
                end
            end
            if (junk && cyc == 2) begin
                start = 1'b1;
                w_wen = 1'b1; w_addr = '0; w_in = 8'd99;
                x_wen = 1'b1; x_addr = '0; x_in = 8'd99;
            end
            step();
            cyc++;
        end
        start = 1'b0; w_wen = 1'b0; x_wen = 1'b0;
        matrix_ready = 1'b1;
        chk({nm, ":done_cyc"}, 32'(done_cyc), 32'(M*(N+1) + 1 + slen));
        chk({nm, ":rows"}, 32'(seen), 32'(M));
        chk({nm, ":valid_cycles"}, 32'(vcyc), 32'(M + slen));
        step();
        chk({nm, ":idle_busy"}, 32'(busy), 0);
        chk({nm, ":idle_done"}, 32'(done), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ":res"}, 32'(matrix_result), 0);
        chk({nm, ":valid"}, 32'(matrix_valid), 0);
        chk({nm, ":row"}, 32'(row_idx), 0);
        chk({nm, ":busy"}, 32'(busy), 0);
        chk({nm, ":done"}, 32'(done), 0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < M * N; i++) W[i] = i + 1;
        fill_x1();
        write_all();
    endtask

    task automatic fill_x1();
        for (int i = 0; i < N; i++) X[i] = 1;
    endtask

    initial begin
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        load_basic();
        chk({"basic:r0"}, 32'(exp_row(0)), 32'h0006);
        run("basic", -1, 0, 1'b0);
        run("stall", 1, 5, 1'b0);
        run("junk", -1, 0, 1'b1);
        run("rerun", -1, 0, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("midrst:busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst:no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        step();
        run("after_rst", -1, 0, 1'b0);

        fill(-128, -128);
        write_all();
        run("sat_pos", -1, 0, 1'b0);
        fill(127, -128);
        write_all();
        run("sat_neg", -1, 0, 1'b0);

        for (int i = 0; i < M * N; i++) W[i] = rnd8();
        W[0] = -1; W[1] = 2; W[2] = -3;
        X[0] = 5; X[1] = -6; X[2] = 7;
        write_all();
        run("signed", -1, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int srow;
            int slen;
            for (int i = 0; i < M * N; i++) W[i] = rnd8();
            for (int i = 0; i < N; i++) X[i] = rnd8();
            write_all();
            slen = int'($urandom_range(0, 4));
            srow = (slen == 0) ? -1 : int'($urandom_range(0, M - 1));
            run($sformatf("rand%0d", r), srow, slen, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
